// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time, programmable wait states.
// Optional macro DMEM_MMIO_LED_EN maps a 16-bit LED register at word address 0xFFFF_F000.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
`ifdef DMEM_MMIO_LED_EN
  output logic [15:0] led_out,
`endif
  output logic        busy
);

  localparam int unsigned AW_B  = ADDR_WIDTH + 2;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`ifdef DMEM_MMIO_LED_EN
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_F000;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [AW_B-1:0]   r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH];
`ifdef DMEM_MMIO_LED_EN
  logic              r_mmio;
  logic [15:0]       r_led;
  logic              w_hit;
`endif

  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_rd_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes;
  logic                  w_ram_we;

  // Request screening, evaluated on the live request while idle
  always_comb begin
    w_err = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) w_err = 1'b1;
    if (req_we && req_funct3[2]) w_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) w_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) w_err = 1'b1;
`ifdef DMEM_MMIO_LED_EN
    w_hit = (req_addr == MMIO_ADDR);
    if (w_hit) begin
      if (req_funct3 != 3'b010) w_err = 1'b1;
    end else if ((req_addr >> AW_B) != 32'd0) begin
      w_err = 1'b1;
    end
`else
    if ((req_addr >> AW_B) != 32'd0) w_err = 1'b1;
`endif
  end

  // Lane selection and extension for loads; lane enables and replicated data for stores
  always_comb begin
    w_idx     = r_addr[AW_B-1:2];
    w_rd_word = r_mem[w_idx];
    w_byte    = w_rd_word[{r_addr[1:0], 3'b000} +: 8];
    w_half    = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = w_rd_word;
    endcase
    case (r_funct3[1:0])
      2'b00: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_wlanes = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
      end
    endcase
`ifdef DMEM_MMIO_LED_EN
    w_ram_we = (r_state == S_ACCESS) && r_we && !r_mmio;
`else
    w_ram_we = (r_state == S_ACCESS) && r_we;
`endif
  end

  // Byte-lane merge write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
`ifdef DMEM_MMIO_LED_EN
      r_mmio      <= 1'b0;
      r_led       <= 16'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[AW_B-1:0];
            r_wdata  <= req_wdata;
`ifdef DMEM_MMIO_LED_EN
            r_mmio   <= w_hit;
`endif
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            if (w_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_err       <= 1'b1;
              r_rdata     <= 32'd0;
            end else if (WAIT_CYCLES == 0) begin
              r_state <= S_ACCESS;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ACCESS: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_err       <= 1'b0;
`ifdef DMEM_MMIO_LED_EN
          if (r_mmio) begin
            if (r_we) r_led <= r_wdata[15:0];
            r_rdata <= r_we ? 32'd0 : {16'h0, r_led};
          end else begin
            r_rdata <= r_we ? 32'd0 : w_load;
          end
`else
          r_rdata     <= r_we ? 32'd0 : w_load;
`endif
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_ready     <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
`ifdef DMEM_MMIO_LED_EN
  assign led_out   = r_led;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus random traffic against a byte-level model.
module tb_dmem_responder;
  localparam int unsigned AW = 12;
  localparam int unsigned WC = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
`ifdef DMEM_MMIO_LED_EN
  logic [15:0] led_out;
`endif

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef DMEM_MMIO_LED_EN
    .led_out(led_out),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  mdl [int unsigned];
  logic [15:0] mdl_led = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size 1/2/4 from funct3[1:0]
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int unsigned size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    err  = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) || (addr % size != 0);
    rd   = 32'd0;
`ifdef DMEM_MMIO_LED_EN
    if (addr == 32'hFFFF_F000) begin
      if (f3 != 3'd2) err = 1'b1;
      if (!err) begin
        if (we) mdl_led = wd[15:0];
        else    rd = {16'h0, mdl_led};
      end
      return;
    end
`endif
    if (addr >= (32'd4 << AW)) err = 1'b1;
    if (err) return;
    if (we) begin
      for (int k = 0; k < int'(size); k++) mdl[addr + k] = 8'(wd >> (8 * k));
    end else begin
      v = 32'd0;
      for (int k = 0; k < int'(size); k++) v = v | (32'(mdl[addr + k]) << (8 * k));
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | (~32'd0 << (8 * size));
      rd = v;
    end
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic        got_err;
    int lat, busy_n, bad;
    model(we, f3, addr, wd, exp_err, exp_rd);
    wait_ready(tag);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    // Junk held on the request bus while busy must be ignored
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1; busy_n = 0; bad = 0;
    while (1) begin
      if (busy) busy_n++;
      if (req_ready) bad++;
      if (rsp_valid || lat >= 50) break;
      @(posedge clk); #1; lat++;
    end
    req_valid = 1'b0;
    got_rd = rsp_rdata; got_err = rsp_err;
    chk({tag, ":latency"}, 32'(lat), exp_err ? 32'd1 : 32'(WC + 2));
    chk({tag, ":err"}, 32'(got_err), 32'(exp_err));
    chk({tag, ":rdata"}, got_rd, exp_rd);
    chk({tag, ":busy_cycles"}, 32'(busy_n), exp_err ? 32'd1 : 32'(WC + 2));
    chk({tag, ":ready_while_busy"}, 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk({tag, ":pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":idle"}, 32'(busy), 32'd0);
    chk({tag, ":hold"}, rsp_rdata, exp_rd);
  endtask

  // Accept a store, then hit reset after n_edges further edges (1 = WAIT, 2 = ACCESS)
  task automatic abort_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                             input int n_edges);
    int seen;
    wait_ready(tag);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (n_edges) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk({tag, ":rst_busy"}, 32'(busy), 32'd0);
    chk({tag, ":rst_ready"}, 32'(req_ready), 32'd0);
    chk({tag, ":rst_rdata"}, rsp_rdata, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":ready_after"}, 32'(req_ready), 32'd1);
    seen = 0;
    repeat (6) begin if (rsp_valid) seen++; @(posedge clk); #1; end
    chk({tag, ":no_rsp"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    chk("reset:ready", 32'(req_ready), 32'd0);
    chk("reset:busy", 32'(busy), 32'd0);
    chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset:rsp_rdata", rsp_rdata, 32'd0);
    chk("reset:rsp_err", 32'(rsp_err), 32'd0);
`ifdef DMEM_MMIO_LED_EN
    chk("reset:led", 32'(led_out), 32'd0);
`endif
    #1 rst = 1'b0;
    #1 chk("release:ready_pre_edge", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("release:ready", 32'(req_ready), 32'd1);

    xact("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    xact("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
    xact("sb_11", 1'b1, 3'b000, 32'h11, 32'h123456AA);
    xact("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0);
    xact("lb_11", 1'b0, 3'b000, 32'h11, 32'h0);
    xact("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0);
    xact("lh_12", 1'b0, 3'b001, 32'h12, 32'h0);
    xact("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0);
    xact("sh_13_mis", 1'b1, 3'b001, 32'h13, 32'hFFFF);
    xact("lw_10c", 1'b0, 3'b010, 32'h10, 32'h0);
    xact("lw_12_mis", 1'b0, 3'b010, 32'h12, 32'h0);
    xact("f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
    xact("sbu_err", 1'b1, 3'b100, 32'h10, 32'h0);
    xact("sh_16", 1'b1, 3'b001, 32'h16, 32'h0000_8001);
    xact("lw_14", 1'b0, 3'b010, 32'h14, 32'h0);
    xact("lw_4000_oor", 1'b0, 3'b010, 32'h4000, 32'h0);
    xact("sw_3ffc", 1'b1, 3'b010, 32'h3FFC, 32'hCAFE_F00D);
    xact("lw_3ffc", 1'b0, 3'b010, 32'h3FFC, 32'h0);

    xact("sw_20_pre", 1'b1, 3'b010, 32'h20, 32'hA5A5_0F0F);
    xact("sw_24_pre", 1'b1, 3'b010, 32'h24, 32'h0BAD_F00D);
    abort_store("abort_wait", 32'h20, 32'h12345678, 1);
    xact("lw_20_kept", 1'b0, 3'b010, 32'h20, 32'h0);
    abort_store("abort_access", 32'h24, 32'h55AA55AA, 2);
    xact("lw_24_kept", 1'b0, 3'b010, 32'h24, 32'h0);

    xact("mmio_sw", 1'b1, 3'b010, 32'hFFFF_F000, 32'h0000_BEEF);
`ifdef DMEM_MMIO_LED_EN
    chk("mmio:led", 32'(led_out), 32'h0000_BEEF);
    xact("mmio_lw", 1'b0, 3'b010, 32'hFFFF_F000, 32'h0);
    xact("mmio_sb", 1'b1, 3'b000, 32'hFFFF_F000, 32'h11);
    chk("mmio:led_kept", 32'(led_out), 32'h0000_BEEF);
`endif

    for (int i = 0; i < 16; i++) xact("init", 1'b1, 3'b010, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 120; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 63));
      xact("rand", 1'($urandom_range(0, 1)), f3, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
